// File: rtl/seg_pkg.sv
// Shared constants for the seven-segment capture path: DE10-Lite active-low
// digit patterns (bit0=a .. bit6=g), BCD codes and FSM state encoding.
package seg_pkg;

    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    localparam logic [3:0] BCD_ERR   = 4'hE;
    localparam logic [3:0] BCD_BLANK = 4'hF;

    typedef enum logic {
        COLLECT = 1'b0,
        PRESENT = 1'b1
    } state_t;

endpackage

// File: rtl/seg7_to_bcd.sv
// Combinational seven-segment pattern to BCD decoder with an unrecognised flag.
// Define SEG_BLANK_DECODE_EN to decode the all-off pattern as a blank digit.
module seg7_to_bcd
    import seg_pkg::*;
(
    input  logic [6:0] seg,
    output logic [3:0] bcd,
    output logic       err
);

    always_comb begin
        bcd = BCD_ERR;
        err = 1'b1;
        case (seg)
            SEG_0: begin bcd = 4'd0; err = 1'b0; end
            SEG_1: begin bcd = 4'd1; err = 1'b0; end
            SEG_2: begin bcd = 4'd2; err = 1'b0; end
            SEG_3: begin bcd = 4'd3; err = 1'b0; end
            SEG_4: begin bcd = 4'd4; err = 1'b0; end
            SEG_5: begin bcd = 4'd5; err = 1'b0; end
            SEG_6: begin bcd = 4'd6; err = 1'b0; end
            SEG_7: begin bcd = 4'd7; err = 1'b0; end
            SEG_8: begin bcd = 4'd8; err = 1'b0; end
            SEG_9: begin bcd = 4'd9; err = 1'b0; end
`ifdef SEG_BLANK_DECODE_EN
            SEG_BLANK: begin bcd = BCD_BLANK; err = 1'b0; end
`else
`endif
            default: begin bcd = BCD_ERR; err = 1'b1; end
        endcase
    end

endmodule

// File: rtl/seg_capture_decoder.sv
// Captures debounced seven-segment digits per slot and presents a full frame
// with valid/ready handshake. Optional macro SEG_BLANK_DECODE_EN (see seg7_to_bcd).
module seg_capture_decoder
    import seg_pkg::*;
#(
    parameter int NUM_DIGITS    = 6,
    parameter int STABLE_CYCLES = 4
)
(
    input  logic                    clk,
    input  logic                    reset,
    input  logic [6:0]              seg_in,
    input  logic [2:0]              seg_idx,
    input  logic                    seg_strobe,
    output logic [4*NUM_DIGITS-1:0] out_bcd,
    output logic [NUM_DIGITS-1:0]   out_err,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic                    busy
);

    localparam int CNT_W = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES - 1);

    state_t                state;
    state_t                state_next;
    logic [2:0]            last_idx;
    logic [6:0]            last_seg;
    logic                  sample_valid;
    logic [CNT_W-1:0]      count;
    logic [CNT_W-1:0]      count_next;
    logic [NUM_DIGITS-1:0] captured;
    logic [NUM_DIGITS-1:0] write_en;
    logic                  collect_strobe;
    logic                  idx_ok;
    logic                  sample_match;
    logic                  accept;
    logic                  transfer;
    logic [3:0]            dec_bcd;
    logic                  dec_err;

    seg7_to_bcd u_decode (
        .seg (seg_in),
        .bcd (dec_bcd),
        .err (dec_err)
    );

    assign busy = (state == PRESENT);

    // count holds (identical samples seen - 1), so a digit is accepted on the
    // STABLE_CYCLES-th consecutive identical strobe and on every one after it.
    always_comb begin
        collect_strobe = (state == COLLECT) && seg_strobe;
        idx_ok         = (32'(seg_idx) < NUM_DIGITS);
        sample_match   = sample_valid && (seg_idx == last_idx) && (seg_in == last_seg);
        transfer       = (state == PRESENT) && out_valid && out_ready;
        count_next     = count;
        accept         = 1'b0;
        write_en       = '0;
        if (collect_strobe && idx_ok) begin
            if (sample_match) begin
                count_next = (count == CNT_MAX) ? CNT_MAX : count + 1'b1;
            end else begin
                count_next = '0;
            end
            accept = (count_next == CNT_MAX);
        end
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (accept && (32'(seg_idx) == k)) begin
                write_en[k] = 1'b1;
            end
        end
    end

    always_comb begin
        state_next = state;
        if (state == COLLECT) begin
            if (&captured) begin
                state_next = PRESENT;
            end
        end else begin
            if (transfer) begin
                state_next = COLLECT;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= COLLECT;
            out_valid    <= 1'b0;
            out_bcd      <= {NUM_DIGITS{BCD_BLANK}};
            out_err      <= '0;
            captured     <= '0;
            count        <= '0;
            sample_valid <= 1'b0;
            last_idx     <= '0;
            last_seg     <= '0;
        end else begin
            state     <= state_next;
            out_valid <= (state_next == PRESENT);
            if (transfer) begin
                captured <= '0;
                count    <= '0;
            end else if (collect_strobe) begin
                // Out-of-range slots break any stability run in progress.
                if (!idx_ok) begin
                    count        <= '0;
                    sample_valid <= 1'b0;
                end else begin
                    last_idx     <= seg_idx;
                    last_seg     <= seg_in;
                    sample_valid <= 1'b1;
                    count        <= count_next;
                    for (int k = 0; k < NUM_DIGITS; k++) begin
                        if (write_en[k]) begin
                            out_bcd[4*k +: 4] <= dec_bcd;
                            out_err[k]        <= dec_err;
                            captured[k]       <= 1'b1;
                        end
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_seg_capture_decoder.sv
// Self-checking bench for seg_capture_decoder: directed scenarios plus random
// strobe traffic compared against a run-length frame model.
module tb_seg_capture_decoder;

    localparam int NDIG   = 6;
    localparam int STABLE = 4;

    logic        clk;
    logic        reset;
    logic [6:0]  seg_in;
    logic [2:0]  seg_idx;
    logic        seg_strobe;
    logic [23:0] out_bcd;
    logic [5:0]  out_err;
    logic        out_valid;
    logic        out_ready;
    logic        busy;

    int tests;
    int fails;

    logic [6:0] digit_pat [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                                   7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                                   7'b0000000, 7'b0010000};

    // Model: frame contents, captured set, and length of the current run of
    // identical strobed samples.
    bit         m_present;
    logic [3:0] m_bcd [NDIG];
    logic       m_err [NDIG];
    bit [5:0]   m_cap;
    bit         m_have;
    logic [2:0] m_idx;
    logic [6:0] m_seg;
    int         m_run;

    seg_capture_decoder #(.NUM_DIGITS(NDIG), .STABLE_CYCLES(STABLE)) dut (
        .clk        (clk),
        .reset      (reset),
        .seg_in     (seg_in),
        .seg_idx    (seg_idx),
        .seg_strobe (seg_strobe),
        .out_bcd    (out_bcd),
        .out_err    (out_err),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void model_decode(input logic [6:0] p, output logic [3:0] b, output logic e);
        b = 4'hE;
        e = 1'b1;
        for (int d = 0; d < 10; d++) begin
            if (p == digit_pat[d]) begin
                b = d[3:0];
                e = 1'b0;
            end
        end
`ifdef SEG_BLANK_DECODE_EN
        if (p == 7'b1111111) begin
            b = 4'hF;
            e = 1'b0;
        end
`endif
    endfunction

    function automatic logic [23:0] model_bcd_vec();
        logic [23:0] v;
        for (int k = 0; k < NDIG; k++) v[4*k +: 4] = m_bcd[k];
        return v;
    endfunction

    function automatic logic [5:0] model_err_vec();
        logic [5:0] v;
        for (int k = 0; k < NDIG; k++) v[k] = m_err[k];
        return v;
    endfunction

    task automatic model_edge(input bit rst, input bit strb, input logic [2:0] idx,
                              input logic [6:0] seg, input bit rdy);
        bit         full;
        logic [3:0] b;
        logic       e;
        if (rst) begin
            m_present = 0;
            m_cap     = '0;
            m_have    = 0;
            m_run     = 0;
            for (int k = 0; k < NDIG; k++) begin
                m_bcd[k] = 4'hF;
                m_err[k] = 1'b0;
            end
        end else if (m_present) begin
            if (rdy) begin
                m_present = 0;
                m_cap     = '0;
                m_run     = m_have ? 1 : 0;
            end
        end else begin
            full = (m_cap == 6'h3F);
            if (strb) begin
                if (int'(idx) >= NDIG) begin
                    m_have = 0;
                    m_run  = 0;
                end else begin
                    if (m_have && idx == m_idx && seg == m_seg) begin
                        m_run++;
                    end else begin
                        m_have = 1;
                        m_idx  = idx;
                        m_seg  = seg;
                        m_run  = 1;
                    end
                    if (m_run >= STABLE) begin
                        model_decode(seg, b, e);
                        m_bcd[idx] = b;
                        m_err[idx] = e;
                        m_cap[idx] = 1'b1;
                    end
                end
            end
            if (full) m_present = 1;
        end
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
            $error("[TB] %s check did not hold", tag);
        end
    endtask

    task automatic applyStimulus(input bit rst, input bit strb, input logic [2:0] idx,
                                 input logic [6:0] seg, input bit rdy);
        reset      = rst;
        seg_strobe = strb;
        seg_idx    = idx;
        seg_in     = seg;
        out_ready  = rdy;
        model_edge(rst, strb, idx, seg, rdy);
        @(posedge clk);
        #1;
        checkOutput("out_valid", 32'(out_valid), 32'(m_present));
        checkOutput("busy", 32'(busy), 32'(m_present));
        checkOutput("out_bcd", 32'(out_bcd), 32'(model_bcd_vec()));
        checkOutput("out_err", 32'(out_err), 32'(model_err_vec()));
    endtask

    task automatic fillSlot(input int slot, input logic [6:0] pat);
        for (int r = 0; r < STABLE; r++) applyStimulus(0, 1, slot[2:0], pat, 0);
    endtask

    initial begin
        logic [6:0] pat;
        logic [2:0] idx;
        int         reps;
        logic [3:0] blank_bcd;
        logic       blank_err;

        tests = 0;
        fails = 0;
        reset = 1'b1;
        seg_strobe = 1'b0;
        seg_idx = '0;
        seg_in = '0;
        out_ready = 1'b0;

        // Reset state
        applyStimulus(1, 0, 0, 0, 0);
        applyStimulus(1, 1, 0, digit_pat[5], 1);
        checkOutput("reset_bcd", 32'(out_bcd), 32'h00FFFFFF);
        checkOutput("reset_err", 32'(out_err), 32'h0);
        checkOutput("reset_valid", 32'(out_valid), 32'h0);
        checkOutput("reset_busy", 32'(busy), 32'h0);

        // Full frame of digits 1..6
        for (int s = 0; s < NDIG; s++) fillSlot(s, digit_pat[s+1]);
        checkOutput("valid_late_by_one", 32'(out_valid), 32'h0);
        applyStimulus(0, 0, 0, 0, 0);
        checkOutput("frame_valid", 32'(out_valid), 32'h1);
        checkOutput("frame_bcd", 32'(out_bcd), 32'h00654321);
        checkOutput("frame_err", 32'(out_err), 32'h0);

        // Hold in PRESENT against random strobes, then transfer
        for (int c = 0; c < 10; c++) begin
            applyStimulus(0, 1, 3'($urandom_range(0, 7)), 7'($urandom), 0);
            checkOutput("hold_bcd", 32'(out_bcd), 32'h00654321);
            checkOutput("hold_valid", 32'(out_valid), 32'h1);
        end
        applyStimulus(0, 0, 0, 0, 1);
        checkOutput("xfer_valid_low", 32'(out_valid), 32'h0);
        checkOutput("xfer_bcd_kept", 32'(out_bcd), 32'h00654321);
        applyStimulus(0, 0, 0, 0, 1);
        checkOutput("ready_idle_no_effect", 32'(out_valid), 32'h0);
        applyStimulus(0, 1, 7, 0, 0);

        // Slot 2: an unstable run of 2 must never be taken
        fillSlot(2, digit_pat[7]);
        checkOutput("slot2_pre", 32'(out_bcd[11:8]), 32'h7);
        for (int r = 0; r < 3; r++) begin
            applyStimulus(0, 1, 2, digit_pat[2], 0);
            checkOutput("slot2_not_2", 32'(out_bcd[11:8] != 4'd2), 32'h1);
        end
        for (int r = 0; r < 5; r++) begin
            applyStimulus(0, 1, 2, digit_pat[3], 0);
            checkOutput("slot2_not_2", 32'(out_bcd[11:8] != 4'd2), 32'h1);
        end
        checkOutput("slot2_is_3", 32'(out_bcd[11:8]), 32'h3);

        // Unrecognised pattern, blank pattern, and the rest of the frame
        fillSlot(0, 7'b1111111);
        fillSlot(1, digit_pat[9]);
        fillSlot(3, digit_pat[0]);
        fillSlot(4, 7'b0000110);
        fillSlot(5, digit_pat[8]);
        applyStimulus(0, 0, 0, 0, 0);
        checkOutput("frame2_valid", 32'(out_valid), 32'h1);
        checkOutput("slot4_err_bcd", 32'(out_bcd[19:16]), 32'hE);
        checkOutput("slot4_err_flag", 32'(out_err[4]), 32'h1);
`ifdef SEG_BLANK_DECODE_EN
        blank_bcd = 4'hF;
        blank_err = 1'b0;
`else
        blank_bcd = 4'hE;
        blank_err = 1'b1;
`endif
        checkOutput("slot0_blank_bcd", 32'(out_bcd[3:0]), 32'(blank_bcd));
        checkOutput("slot0_blank_err", 32'(out_err[0]), 32'(blank_err));
        applyStimulus(0, 0, 0, 0, 1);
        applyStimulus(0, 1, 7, 0, 0);

        // Random traffic: runs of repeated samples, gaps, random ready
        for (int n = 0; n < 400; n++) begin
            idx = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(6, 7)) : 3'($urandom_range(0, 5));
            pat = ($urandom_range(0, 7) == 0) ? 7'($urandom) : digit_pat[$urandom_range(0, 9)];
            reps = $urandom_range(1, 6);
            for (int r = 0; r < reps; r++) begin
                applyStimulus(0, 1, idx, pat, $urandom_range(0, 3) == 0);
                if ($urandom_range(0, 3) == 0) applyStimulus(0, 0, 0, 0, $urandom_range(0, 3) == 0);
            end
        end

        // Reset coinciding with the final slot write
        applyStimulus(1, 0, 0, 0, 0);
        for (int s = 0; s < 5; s++) fillSlot(s, digit_pat[s]);
        for (int r = 0; r < 3; r++) applyStimulus(0, 1, 5, digit_pat[5], 0);
        applyStimulus(1, 1, 5, digit_pat[5], 1);
        checkOutput("rst_win_valid", 32'(out_valid), 32'h0);
        checkOutput("rst_win_bcd", 32'(out_bcd), 32'h00FFFFFF);
        applyStimulus(0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0);
        checkOutput("rst_win_still_idle", 32'(out_valid), 32'h0);
        fillSlot(5, digit_pat[5]);
        applyStimulus(0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0);
        checkOutput("rst_cleared_captured", 32'(out_valid), 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
